// File: rtl/apb_seq_pkg.sv
// apb_seq_pkg: shared types for the APB command sequencer.
//   op_e    - command table op codes
//   state_e - sequencer FSM state encoding (exported on fsm_state)
//   err_e   - error codes reported on err_code
package apb_seq_pkg;

  typedef enum logic [1:0] {
    OP_END   = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_POLL  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_SLVERR    = 2'd1,
    ERR_POLL_TMO  = 2'd2,
    ERR_READY_TMO = 2'd3
  } err_e;

  // States in which the table may be rewritten and a new run started.
  function automatic logic is_parked(state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/apb_seq_cmd_table.sv
// apb_seq_cmd_table: NUM_CMDS-entry command register file.
//   clk, rst          - clock, synchronous active-high reset (clears ops to END)
//   we, wr_idx, wr_*  - synchronous write port; wr_idx >= NUM_CMDS is ignored
//   rd_idx, rd_*      - asynchronous read port; out-of-range index reads END
module apb_seq_cmd_table
  import apb_seq_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_CMDS = 8,
  parameter int IDX_W    = $clog2(NUM_CMDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  op_e               wr_op,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_mask,
  input  logic [IDX_W-1:0]  rd_idx,
  output op_e               rd_op,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rd_mask
);

  op_e               op_q   [NUM_CMDS];
  op_e               op_d   [NUM_CMDS];
  logic [ADDR_W-1:0] addr_q [NUM_CMDS];
  logic [ADDR_W-1:0] addr_d [NUM_CMDS];
  logic [DATA_W-1:0] data_q [NUM_CMDS];
  logic [DATA_W-1:0] data_d [NUM_CMDS];
  logic [DATA_W-1:0] mask_q [NUM_CMDS];
  logic [DATA_W-1:0] mask_d [NUM_CMDS];

  always_comb begin
    op_d   = op_q;
    addr_d = addr_q;
    data_d = data_q;
    mask_d = mask_q;
    for (int i = 0; i < NUM_CMDS; i++) begin
      if (we && (wr_idx == IDX_W'(i))) begin
        op_d[i]   = wr_op;
        addr_d[i] = wr_addr;
        data_d[i] = wr_data;
        mask_d[i] = wr_mask;
      end
    end
  end

  // Only the op field needs reset: an END entry never looks at the rest.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CMDS; i++) begin
      op_q[i]   <= rst ? OP_END : op_d[i];
      addr_q[i] <= addr_d[i];
      data_q[i] <= data_d[i];
      mask_q[i] <= mask_d[i];
    end
  end

  always_comb begin
    rd_op   = OP_END;
    rd_addr = '0;
    rd_data = '0;
    rd_mask = '0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_op   = op_q[i];
        rd_addr = addr_q[i];
        rd_data = data_q[i];
        rd_mask = mask_q[i];
      end
    end
  end

endmodule

// File: rtl/apb_seq_driver.sv
// apb_seq_driver: APB master that executes a loadable WRITE/READ/POLL table.
//   clk, rst                    - clock, synchronous active-high reset
//   start, step, mode_auto      - run control (auto gaps or one command per step)
//   cmd_we, cmd_wr_idx, cmd_*   - command table load port
//   paddr..pwrite               - APB master outputs
//   prdata, pready, pslverr     - APB slave responses
//   rd_data, cmd_idx, fsm_state - last read/poll data, current index, state
//   busy, done, error, err_code - status
//
// state  | meaning
// IDLE   | after reset, waiting for start
// WAIT   | gap before the next command (auto gap, step pulse, or poll retry gap)
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, waiting for pready with timeout
// DONE   | table finished, waiting for start
// ERROR  | slave error or timeout, waiting for start
module apb_seq_driver
  import apb_seq_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_CMDS = 8,
  parameter int IDX_W    = $clog2(NUM_CMDS + 1),
  parameter int GAP_CYC  = 50_000_000,
  parameter int POLL_GAP = 5_000_000,
  parameter int POLL_MAX = 255,
  parameter int TMO_CYC  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              mode_auto,
  input  logic              cmd_we,
  input  logic [IDX_W-1:0]  cmd_wr_idx,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  cmd_idx,
  output logic [2:0]        fsm_state,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int GAP_MAX = (GAP_CYC > POLL_GAP) ? GAP_CYC : POLL_GAP;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam int TMO_W   = $clog2(TMO_CYC + 1);
  localparam int PCNT_W  = $clog2(POLL_MAX + 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              retry_q, retry_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  err_e              err_q, err_d;

  op_e               tbl_op;
  logic [ADDR_W-1:0] tbl_addr;
  logic [DATA_W-1:0] tbl_data;
  logic [DATA_W-1:0] tbl_mask;
  logic              advance;
  logic [IDX_W-1:0]  idx_inc;
  logic [PCNT_W-1:0] pcnt_inc;

  apb_seq_cmd_table #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_CMDS (NUM_CMDS),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (cmd_we && is_parked(state_q)),
    .wr_idx  (cmd_wr_idx),
    .wr_op   (op_e'(cmd_op)),
    .wr_addr (cmd_addr),
    .wr_data (cmd_data),
    .wr_mask (cmd_mask),
    .rd_idx  (idx_q),
    .rd_op   (tbl_op),
    .rd_addr (tbl_addr),
    .rd_data (tbl_data),
    .rd_mask (tbl_mask)
  );

  // Saturate at NUM_CMDS so a table without END still terminates.
  assign idx_inc  = (idx_q == IDX_W'(NUM_CMDS)) ? idx_q : idx_q + IDX_W'(1);
  assign pcnt_inc = pcnt_q + PCNT_W'(1);

  // A poll retry gap is timed in both modes; a step only starts new commands.
  assign advance = retry_q ? (gap_q == '0)
                           : (mode_auto ? (gap_q == '0) : step);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    pcnt_d    = pcnt_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          idx_d   = '0;
          err_d   = ERR_NONE;
          pcnt_d  = '0;
          gap_d   = GAP_W'(GAP_CYC);
          retry_d = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
        if (advance) begin
          retry_d = 1'b0;
          if ((idx_q == IDX_W'(NUM_CMDS)) || (tbl_op == OP_END)) begin
            state_d = ST_DONE;
          end else begin
            paddr_d   = tbl_addr;
            pwrite_d  = (tbl_op == OP_WRITE);
            pwdata_d  = (tbl_op == OP_WRITE) ? tbl_data : '0;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            state_d   = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        tmo_d     = TMO_W'(TMO_CYC - 1);
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          gap_d     = GAP_W'(GAP_CYC);
          state_d   = ST_WAIT;
          if (pslverr) begin
            err_d   = ERR_SLVERR;
            state_d = ST_ERROR;
          end else if (tbl_op == OP_POLL) begin
            rd_data_d = prdata;
            if ((prdata & tbl_mask) == '0) begin
              idx_d  = idx_inc;
              pcnt_d = '0;
            end else if (pcnt_inc == PCNT_W'(POLL_MAX)) begin
              pcnt_d  = pcnt_inc;
              err_d   = ERR_POLL_TMO;
              state_d = ST_ERROR;
            end else begin
              pcnt_d  = pcnt_inc;
              gap_d   = GAP_W'(POLL_GAP);
              retry_d = 1'b1;
            end
          end else begin
            if (tbl_op == OP_READ) rd_data_d = prdata;
            idx_d = idx_inc;
          end
        end else if (tmo_q == '0) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          err_d     = ERR_READY_TMO;
          state_d   = ST_ERROR;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      retry_q   <= 1'b0;
      tmo_q     <= '0;
      pcnt_q    <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      rd_data_q <= '0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      pcnt_q    <= pcnt_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign rd_data   = rd_data_q;
  assign cmd_idx   = idx_q;
  assign fsm_state = state_q;
  assign err_code  = err_q;
  assign busy      = (state_q == ST_WAIT) || (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);

endmodule
